// File: rtl/capture_pkg.sv
// capture_pkg: shared widths, FSM state encoding and the masked trigger
// compare used by the logic-analyzer capture controller.
package capture_pkg;

    localparam int CAP_ADDR_W = 11;
    localparam int CAP_DATA_W = 8;
    localparam int CAP_DEPTH  = 2 ** CAP_ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } capture_state_t;

    // A sample matches when every bit selected by the mask equals the value.
    function automatic logic trig_match(
        input logic [CAP_DATA_W-1:0] sample,
        input logic [CAP_DATA_W-1:0] mask,
        input logic [CAP_DATA_W-1:0] value
    );
        return ((sample ^ value) & mask) == '0;
    endfunction

endpackage

// File: rtl/capture_trig.sv
// capture_trig: level trigger comparator. With CAPTURE_EDGE_TRIG_EN defined it
// also remembers whether the previous accepted sample matched, so trig_edge
// can demand a transition from non-match into match.
module capture_trig
    import capture_pkg::*;
#(
    parameter int DATA_W = CAP_DATA_W
) (
`ifdef CAPTURE_EDGE_TRIG_EN
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_trig_edge,
    input  logic              i_accept,
    input  logic              i_clear,
`endif
    input  logic [DATA_W-1:0] i_sample,
    input  logic [DATA_W-1:0] i_mask,
    input  logic [DATA_W-1:0] i_value,
    output logic              o_hit
);

    logic w_level;

    assign w_level = trig_match(i_sample, i_mask, i_value);

`ifdef CAPTURE_EDGE_TRIG_EN
    // The mask and value are frozen for a whole capture, so keeping only the
    // previous sample's match result is equivalent to keeping the sample.
    logic r_prev_valid;
    logic r_prev_match;

    // Track the match state of the last accepted sample; arm forgets history.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev_valid <= 1'b0;
            r_prev_match <= 1'b0;
        end else if (i_clear) begin
            r_prev_valid <= 1'b0;
            r_prev_match <= 1'b0;
        end else if (i_accept) begin
            r_prev_valid <= 1'b1;
            r_prev_match <= w_level;
        end
    end

    assign o_hit = w_level & (~i_trig_edge | (r_prev_valid & ~r_prev_match));
`else
    assign o_hit = w_level;
`endif

endmodule

// File: rtl/capture_ctrl.sv
// capture_ctrl: circular sample capture into a 2K x 8 BRAM with masked
// trigger, programmable pre-trigger depth and chronological readout.
// Optional edge trigger (trig_edge port) under CAPTURE_EDGE_TRIG_EN.
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int ADDR_W = CAP_ADDR_W,
    parameter int DATA_W = CAP_DATA_W,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              arm,
    input  logic              abort,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] trig_mask,
    input  logic [DATA_W-1:0] trig_value,
`ifdef CAPTURE_EDGE_TRIG_EN
    input  logic              trig_edge,
`endif
    input  logic [ADDR_W-1:0] pre_count,
    input  logic              rd_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_last,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int                CNT_W  = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  R_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  R_FULL = CNT_W'(DEPTH);

    capture_state_t    r_state;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] r_pre;
    logic [ADDR_W-1:0] r_post_rem;
    logic [ADDR_W-1:0] r_trig_addr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_rd_rem;
    logic [DATA_W-1:0] r_mask;
    logic [DATA_W-1:0] r_value;

    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic              r_rd_p1;
    logic              r_last_p1;
    logic              r_rd_valid;
    logic              r_rd_last;

    logic              w_capturing;
    logic              w_arm_ok;
    logic              w_accept;
    logic              w_rd_issue;
    logic              w_hit;
    logic [ADDR_W-1:0] w_cnt_nxt;

    // Abort outranks everything, so it gates arm, sample acceptance and reads.
    assign w_capturing = (r_state == ST_PRE) || (r_state == ST_ARMED) || (r_state == ST_POST);
    assign w_arm_ok    = arm && !abort && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_accept    = sample_valid && !abort && w_capturing;
    assign w_rd_issue  = rd_req && !abort && !w_arm_ok && (r_state == ST_DONE) && (r_rd_rem != '0);
    assign w_cnt_nxt   = r_cnt + A_ONE;

    capture_trig #(
        .DATA_W      (DATA_W)
    ) u_trig (
`ifdef CAPTURE_EDGE_TRIG_EN
        .i_clk       (CLK),
        .i_rst_n     (RST_n),
        .i_trig_edge (trig_edge),
        .i_accept    (w_accept),
        .i_clear     (w_arm_ok),
`endif
        .i_sample    (sample_in),
        .i_mask      (r_mask),
        .i_value     (r_value),
        .o_hit       (w_hit)
    );

    // Capture FSM plus write/read pointers and the pre/post/read counters.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= '0;
            r_cnt       <= '0;
            r_pre       <= '0;
            r_post_rem  <= '0;
            r_trig_addr <= '0;
            r_rd_ptr    <= '0;
            r_rd_rem    <= '0;
            r_mask      <= '0;
            r_value     <= '0;
        end else if (abort) begin
            r_state <= ST_IDLE;
        end else if (w_arm_ok) begin
            r_pre    <= pre_count;
            r_mask   <= trig_mask;
            r_value  <= trig_value;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
            r_state  <= (pre_count == '0) ? ST_ARMED : ST_PRE;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + A_ONE;
                case (r_state)
                    ST_PRE: begin
                        r_cnt <= w_cnt_nxt;
                        if (w_cnt_nxt == r_pre) begin
                            r_state <= ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        if (w_hit) begin
                            r_trig_addr <= r_wr_ptr;
                            r_post_rem  <= A_LAST - r_pre;
                            if (r_pre == A_LAST) begin
                                r_state  <= ST_DONE;
                                r_rd_ptr <= r_wr_ptr - r_pre;
                                r_rd_rem <= R_FULL;
                            end else begin
                                r_state <= ST_POST;
                            end
                        end
                    end
                    ST_POST: begin
                        r_post_rem <= r_post_rem - A_ONE;
                        if (r_post_rem == A_ONE) begin
                            r_state  <= ST_DONE;
                            r_rd_ptr <= r_trig_addr - r_pre;
                            r_rd_rem <= R_FULL;
                        end
                    end
                    default: begin
                    end
                endcase
            end
            if (w_rd_issue) begin
                r_rd_ptr <= r_rd_ptr + A_ONE;
                r_rd_rem <= r_rd_rem - R_ONE;
            end
        end
    end

    // Registered BRAM port: a write per accepted sample, a read per granted request.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_accept) begin
            r_mem_en    <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_wr_ptr;
            r_mem_wdata <= sample_in;
        end else if (w_rd_issue) begin
            r_mem_en   <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= r_rd_ptr;
        end else begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
        end
    end

    // Two-stage read tag pipeline matching the BRAM's registered read data.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_rd_p1    <= 1'b0;
            r_last_p1  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
        end else if (abort) begin
            r_rd_p1    <= 1'b0;
            r_last_p1  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
        end else begin
            r_rd_p1    <= w_rd_issue;
            r_last_p1  <= w_rd_issue && (r_rd_rem == R_ONE);
            r_rd_valid <= r_rd_p1;
            r_rd_last  <= r_last_p1;
        end
    end

    assign rd_data   = r_rd_valid ? mem_rdata : '0;
    assign rd_valid  = r_rd_valid;
    assign rd_last   = r_rd_last;
    assign busy      = w_capturing;
    assign done      = (r_state == ST_DONE);
    assign trig_addr = r_trig_addr;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule
